// File: rtl/imem_loader.sv
// imem_loader
// Program loader that fills instruction memory before the pipeline runs.
// A host streams a framed program over a valid/ready handshake: a length
// header N, then N instruction words, then an XOR checksum of those words.
// Each instruction word is written to instruction memory at addresses
// 0..N-1. The PC/IF stage is held until a load finishes with a good checksum.
//
// Ports:
//   clock     rising-edge clock shared with the pipeline
//   reset     asynchronous, active-high
//   start     single-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_valid  host has a word on in_data
//   in_data   header, instruction or checksum word
//   in_ready  loader accepts in_data this cycle (registered)
//   wr_en     instruction memory write strobe
//   wr_addr   word address of the write
//   wr_data   instruction word being written
//   cpu_hold  while high, PC must not advance and IF/ID must not capture
//   done      level; load completed with a good checksum
//   error     level; length overflow or checksum mismatch
//   loaded    instruction words written in the current or last load
module imem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [31:0] loaded
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        accept;

    // The counter doubles as the address of the next write and the
    // loaded count, since both start at 0 and advance on every word.
    always_comb begin
        accept    = in_valid && in_ready_q;
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_HEADER;
                    count_d = 32'd0;
                    acc_d   = 32'd0;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    len_d = in_data;
                    if (in_data > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else if (in_data == 32'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = in_data;
                    count_d   = count_q + 32'd1;
                    acc_d     = acc_q ^ in_data;
                    if (count_q + 32'd1 == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (in_data == acc_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so that they are
        // registered yet line up with the state they describe.
        in_ready_d = (state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_CHECK);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= 32'd0;
            count_q    <= 32'd0;
            acc_q      <= 32'd0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;
    assign loaded   = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Drives framed program loads into imem_loader from a table of frames
// (header, up to four words, checksum, expected outcome), then runs a
// full-depth load and a reset-in-the-middle sequence by hand.
module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] loaded;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .loaded   (loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        string            name;
        int               n;
        logic [3:0][31:0] words;
        logic [31:0]      checksum;
        bit               gaps;
        bit               expDone;
        bit               expError;
    } vector_t;

    vector_t     vec [7];
    int          assertCount = 0;
    int          failCount   = 0;
    int          cycle       = 0;
    logic [31:0] logAddr [$];
    logic [31:0] logData [$];
    int          logCycle [$];
    logic [31:0] bigWords [DEPTH];
    logic [31:0] bigSum;

    // Cycle stamp for every write strobe, captured mid-cycle.
    always @(posedge clock) cycle++;

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            logAddr.push_back(wr_addr);
            logData.push_back(wr_data);
            logCycle.push_back(cycle);
        end
    end

    // Hard stop in case the DUT wedges somewhere no local bound covers.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vector_t makeVec(input string name, input int n,
                                        input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3,
                                        input logic [31:0] cs, input bit gaps,
                                        input bit expDone, input bit expError);
        vector_t v;
        v.name     = name;
        v.n        = n;
        v.words[0] = w0;
        v.words[1] = w1;
        v.words[2] = w2;
        v.words[3] = w3;
        v.checksum = cs;
        v.gaps     = gaps;
        v.expDone  = expDone;
        v.expError = expError;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the
    // rising edge that accepted the word, with in_valid dropped.
    task automatic sendWord(input logic [31:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) checkOutput("in_ready timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic idleCycle(input bit withStart);
        in_valid = 1'b0;
        start    = withStart;
        @(negedge clock);
        start    = 1'b0;
    endtask

    task automatic applyStimulus(input vector_t v);
        logAddr.delete();
        logData.delete();
        logCycle.delete();
        pulseStart();
        checkOutput({v.name, " start in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({v.name, " start done"}, {31'd0, done}, 32'd0);
        checkOutput({v.name, " start error"}, {31'd0, error}, 32'd0);
        checkOutput({v.name, " start cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        checkOutput({v.name, " start loaded"}, loaded, 32'd0);
        sendWord(32'(v.n));
        if (v.n > DEPTH) return;
        for (int i = 0; i < v.n; i++) begin
            if (v.gaps) idleCycle(1'b1);
            sendWord(v.words[i]);
        end
        if (v.gaps) idleCycle(1'b1);
        sendWord(v.checksum);
    endtask

    task automatic verifyFrame(input vector_t v);
        int expN;
        expN = (v.n > DEPTH) ? 0 : v.n;
        checkOutput({v.name, " done"}, {31'd0, done}, {31'd0, v.expDone});
        checkOutput({v.name, " error"}, {31'd0, error}, {31'd0, v.expError});
        checkOutput({v.name, " cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !v.expDone});
        checkOutput({v.name, " in_ready"}, {31'd0, in_ready}, 32'd0);
        checkOutput({v.name, " loaded"}, loaded, 32'(expN));
        checkOutput({v.name, " write count"}, 32'(logAddr.size()), 32'(expN));
        for (int i = 0; i < expN && i < logAddr.size(); i++) begin
            checkOutput($sformatf("%s wr_addr[%0d]", v.name, i), logAddr[i], 32'(i));
            checkOutput($sformatf("%s wr_data[%0d]", v.name, i), logData[i], v.words[i]);
            if (!v.gaps && i > 0)
                checkOutput($sformatf("%s write spacing[%0d]", v.name, i),
                            32'(logCycle[i] - logCycle[i-1]), 32'd1);
        end
    endtask

    initial begin
        vec[0] = makeVec("normal",   3, 32'h11, 32'h22, 32'h44, 32'h0, 32'h77, 1'b0, 1'b1, 1'b0);
        vec[1] = makeVec("empty ok", 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        vec[2] = makeVec("empty bad", 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 1'b0, 1'b0, 1'b1);
        vec[3] = makeVec("bad sum",  2, 32'hA, 32'hB, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        vec[4] = makeVec("gaps",     4, 32'h1, 32'h2, 32'h3, 32'h4, 32'h4, 1'b1, 1'b1, 1'b0);
        vec[5] = makeVec("overflow", 257, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        vec[6] = makeVec("single",   1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (3) @(negedge clock);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("reset wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("reset wr_addr", wr_addr, 32'd0);
        checkOutput("reset wr_data", wr_data, 32'd0);
        checkOutput("reset cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset error", {31'd0, error}, 32'd0);
        checkOutput("reset loaded", loaded, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] running %0d table frames", 7);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(vec[k]);
            verifyFrame(vec[k]);
        end

        // Full-depth load: exactly DEPTH words is legal.
        $display("[TB] full-depth load");
        bigSum = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            bigWords[i] = (32'(i) * 32'h01010101) ^ 32'hA5000000;
            bigSum      = bigSum ^ bigWords[i];
        end
        logAddr.delete();
        logData.delete();
        logCycle.delete();
        pulseStart();
        sendWord(32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) sendWord(bigWords[i]);
        sendWord(bigSum);
        checkOutput("full done", {31'd0, done}, 32'd1);
        checkOutput("full cpu_hold", {31'd0, cpu_hold}, 32'd0);
        checkOutput("full loaded", loaded, 32'(DEPTH));
        checkOutput("full write count", 32'(logAddr.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < logAddr.size(); i++) begin
            checkOutput($sformatf("full wr_addr[%0d]", i), logAddr[i], 32'(i));
            checkOutput($sformatf("full wr_data[%0d]", i), logData[i], bigWords[i]);
        end

        // Reset while a write strobe is in flight.
        $display("[TB] reset mid-load");
        pulseStart();
        sendWord(32'd5);
        sendWord(32'h100);
        sendWord(32'h200);
        checkOutput("midload wr_en before reset", {31'd0, wr_en}, 32'd1);
        checkOutput("midload loaded before reset", loaded, 32'd2);
        reset = 1'b1;
        #1;
        checkOutput("midload wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("midload cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("midload loaded", loaded, 32'd0);
        checkOutput("midload in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("midload wr_addr", wr_addr, 32'd0);
        checkOutput("midload wr_data", wr_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post reset idle in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(vec[0]);
        verifyFrame(vec[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills instruction memory before the pipeline runs. It accepts a framed word stream from a host over a valid/ready handshake: a length header, then N instruction words, then an XOR checksum. Each instruction word is written into instruction memory at sequential addresses from 0. The block holds the PC/IF stage until a load completes with a good checksum. It sits upstream of InstructionMemory's write port and beside PC.

## Interface
- DEPTH, 256, instruction memory capacity in words; legal N is 0..DEPTH
- clock  in  1  rising-edge clock shared with the pipeline
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR only
- in_valid  in  1  host has a word on in_data
- in_data  in  32  header, instruction or checksum word
- in_ready  out  1  loader accepts in_data this cycle
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  32  word address, 0..N-1
- wr_data  out  32  instruction word
- cpu_hold  out  1  while 1, PC must not advance and IF/ID must not capture
- done  out  1  level; load completed with a good checksum
- error  out  1  level; length overflow or checksum mismatch
- loaded  out  32  count of instruction words written in the current or last load

## Operation
- States: IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
- IDLE: in_ready=0, cpu_hold=1. On start, go to HEADER and clear loaded, the checksum accumulator and the address counter.
- HEADER: in_ready=1. On accept, latch N=in_data.
  - N > DEPTH: go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to LOAD.
- LOAD: in_ready=1. On each accept:
  - wr_data <= in_data, wr_addr <= address counter, wr_en pulses for one cycle.
  - Address counter and loaded increment.
  - Accumulator ^= in_data.
  - After the N-th accept, go to CHECK.
- CHECK: in_ready=1. On accept, compare in_data with the accumulator. Match goes to DONE; mismatch goes to ERROR.
- DONE: done=1, cpu_hold=0, in_ready=0. start clears done, sets cpu_hold=1 and goes to HEADER (reload).
- ERROR: error=1, cpu_hold=1, in_ready=0. start clears error and goes to HEADER.
- start in HEADER, LOAD or CHECK is ignored.
- Words are accepted only when in_valid and in_ready are both high at a rising clock edge. in_valid gaps stall the FSM without side effects.
- Address counter and loaded are 32-bit. Because N ≤ DEPTH, they never wrap.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - cpu_hold=1, done=0, error=0, loaded=0
- All outputs are registered. No combinational path from in_valid to in_ready.
- Write latency: a word accepted at edge k has wr_en=1 with its wr_addr/wr_data during the cycle after edge k (one cycle). Throughput is one word per cycle.
- Transition into CHECK/DONE/ERROR takes effect at the accepting edge. done, error and cpu_hold change in the cycle after that edge.
- in_ready drops the cycle after the checksum accept or the overflow header accept. No word is accepted beyond the frame.
- The last wr_en pulse (word N-1) coincides with the CHECK cycle and completes before DONE can assert.
- Reset mid-load: all outputs return to reset values asynchronously, and any in-flight wr_en is dropped. Memory contents already written are left untouched.
- The pipeline sees cpu_hold fall the same cycle done rises, so PC fetches address 0 on the following edge.

## Test plan
- Normal load: start; send header 3, words 0x11,0x22,0x44, checksum 0x77, valid every cycle -> writes (0,0x11),(1,0x22),(2,0x44) on consecutive cycles; loaded=3; done=1; cpu_hold=0.
- Empty program: header 0, checksum 0 -> no wr_en; done=1. Repeat with checksum 5 -> error=1, cpu_hold=1.
- Bad checksum: header 2, words 0xA,0xB, checksum 0x0 -> two writes occur, then error=1, done=0, cpu_hold=1; a further start returns to HEADER with error=0.
- Overflow: DEPTH=256, header 257 -> error=1 next cycle, in_ready=0, no wr_en; header exactly 256 with correct checksum -> 256 writes, last at addr 255, done=1.
- Backpressure/gaps: toggle in_valid every other cycle during header 4 -> each word written exactly once at addr 0..3 in order; start pulses mid-LOAD are ignored.
- Reset mid-load: assert reset after 2 of 5 words -> wr_en=0, cpu_hold=1, loaded=0, state IDLE immediately; new start plus a full frame completes with done=1.
